// File: rtl/digit_serial_add_sub.sv
// Digit-serial unsigned adder/subtractor: D bits of A and B per clock through a
// D-bit ripple slice. The carry is kept in a register between digits, giving an (N+1)-bit result.
module digit_serial_add_sub #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         k,
    output logic         busy,
    output logic         done,
    output logic [N:0]   S
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (N < 1 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
            $error("digit_serial_add_sub: need N >= 1, 1 <= D <= N and N %% D == 0");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic           r_carry;
    logic           r_k;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_part;
    logic [N:0]     r_s;
    logic           r_done;

    logic           w_accept;
    logic           w_last;
    logic [D-1:0]   w_a_sl;
    logic [D-1:0]   w_b_sl;
    logic [D-1:0]   w_sum;
    logic [D:0]     w_c;
    logic [N-1:0]   w_part_next;

    // One D-bit ripple slice. The digit is selected by the counter. Its sum is merged into the partial result.
    always_comb begin
        w_a_sl = r_a[int'(r_cnt) * D +: D];
        w_b_sl = r_b[int'(r_cnt) * D +: D];
        w_c    = '0;
        w_sum  = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < D; i++) begin
            w_sum[i]   = w_a_sl[i] ^ w_b_sl[i] ^ w_c[i];
            w_c[i+1]   = (w_a_sl[i] & w_b_sl[i]) | (w_c[i] & (w_a_sl[i] ^ w_b_sl[i]));
        end
        w_part_next = r_part;
        w_part_next[int'(r_cnt) * D +: D] = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1. The +1 enters as the initial carry.
    // S[N] is k XOR carry-out, so it flags a borrow when subtracting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_k     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_s     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= k ? ~B : B;
                r_k     <= k;
                r_carry <= k;
                r_cnt   <= '0;
                r_part  <= '0;
            end else if (r_state == RUN) begin
                r_part  <= w_part_next;
                r_carry <= w_c[D];
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_s <= {r_k ^ w_c[D], w_part_next};
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign S    = r_s;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Directed handshake tests on an N=8/D=2 instance.
// Randomized sweeps over several N/D configurations are checked against an arithmetic reference model.
module tb_digit_serial_add_sub;

    logic       clk;
    logic       rst;
    logic       rst_sw;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       k;
    logic       busy;
    logic       done;
    logic [8:0] s;

    int errors = 0;
    int checks = 0;

    localparam int NC = 5;
    localparam int CFG_N [NC] = '{8, 8, 8, 8, 12};
    localparam int CFG_D [NC] = '{1, 2, 4, 8, 3};
    localparam int OPS = 1000;

    logic [NC-1:0] sweep_fin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    digit_serial_add_sub #(.N(8), .D(2)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .S     (s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges from the current sample point until done; lat=0 if it never comes.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ik,
                         input logic [8:0] exp, input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        a = ia; b = ib; k = ik; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check({tag, "_s"}, 64'(s), 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_busy_cycles"}, 64'(bcnt + 1), 64'd4);
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    genvar g;
    generate
        for (g = 0; g < NC; g++) begin : g_sweep
            localparam int GN    = CFG_N[g];
            localparam int GD    = CFG_D[g];
            localparam int GNDIG = GN / GD;

            logic          sw_start;
            logic          sw_k;
            logic          sw_busy;
            logic          sw_done;
            logic [GN-1:0] sw_a;
            logic [GN-1:0] sw_b;
            logic [GN:0]   sw_s;
            logic          fin;

            assign sweep_fin[g] = fin;

            digit_serial_add_sub #(.N(GN), .D(GD)) u_dut (
                .clk   (clk),
                .rst   (rst_sw),
                .start (sw_start),
                .A     (sw_a),
                .B     (sw_b),
                .k     (sw_k),
                .busy  (sw_busy),
                .done  (sw_done),
                .S     (sw_s)
            );

            initial begin
                logic [63:0] mask;
                logic [63:0] exp;
                int          lat;
                fin      = 1'b0;
                sw_start = 1'b0;
                sw_a     = '0;
                sw_b     = '0;
                sw_k     = 1'b0;
                mask     = (64'd1 << (GN + 1)) - 64'd1;
                repeat (4) @(negedge clk);
                for (int n = 0; n < OPS; n++) begin
                    @(negedge clk);
                    sw_a     = GN'($urandom);
                    sw_b     = GN'($urandom);
                    sw_k     = 1'($urandom);
                    sw_start = 1'b1;
                    exp = sw_k ? ((64'(sw_a) - 64'(sw_b)) & mask)
                               : ((64'(sw_a) + 64'(sw_b)) & mask);
                    @(posedge clk); #1;
                    sw_start = 1'b0;
                    sw_a     = GN'($urandom);
                    sw_b     = GN'($urandom);
                    sw_k     = ~sw_k;
                    check($sformatf("sw%0d_busy", g), 64'(sw_busy), 64'd1);
                    lat = 0;
                    for (int c = 1; c <= 4 * GNDIG + 4; c++) begin
                        @(posedge clk); #1;
                        if (sw_done) begin
                            lat = c;
                            break;
                        end
                    end
                    check($sformatf("sw%0d_s", g), 64'(sw_s), exp);
                    check($sformatf("sw%0d_lat", g), 64'(lat), 64'(GNDIG));
                end
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        rst    = 1'b1;
        rst_sw = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        k      = 1'b0;
        repeat (2) @(negedge clk);
        rst_sw = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_s", 64'(s), 64'd0);
        rst = 1'b0;

        do_op(8'd200, 8'd100, 1'b0, 9'h12C, "add_200_100");
        do_op(8'd100, 8'd30,  1'b1, 9'h046, "sub_100_30");
        do_op(8'd30,  8'd100, 1'b1, 9'h1BA, "sub_30_100");
        do_op(8'd255, 8'd255, 1'b0, 9'h1FE, "add_max");
        do_op(8'd0,   8'd0,   1'b1, 9'h000, "sub_zero");
        do_op(8'd0,   8'd255, 1'b1, 9'h101, "sub_0_255");

        // A second start while busy must be ignored.
        @(negedge clk);
        a = 8'd50; b = 8'd20; k = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd7; b = 8'd3; k = 1'b1;
        fork
            wait_done(lat, bcnt);
            begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        check("midstart_s", 64'(s), 64'h046);
        check("midstart_lat", 64'(lat), 64'd4);
        @(posedge clk); #1;
        check("midstart_no_extra", 64'(busy | done), 64'd0);

        // Back-to-back: start held in the done cycle is accepted at once.
        @(negedge clk);
        a = 8'd1; b = 8'd2; k = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b_first_s", 64'(s), 64'h003);
        a = 8'd9; b = 8'd4; k = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept_busy", 64'(busy), 64'd1);
        check("b2b_hold_s", 64'(s), 64'h003);
        wait_done(lat, bcnt);
        check("b2b_second_s", 64'(s), 64'h005);
        check("b2b_second_lat", 64'(lat), 64'd4);

        // Reset two cycles into an operation aborts it without a done pulse.
        @(negedge clk);
        a = 8'd200; b = 8'd100; k = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_s", 64'(s), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        do_op(8'd200, 8'd100, 1'b0, 9'h12C, "after_abort");

        for (int c = 0; c < 60000 && !(&sweep_fin); c++) @(posedge clk);
        check("sweep_finished", 64'(sweep_fin), 64'({NC{1'b1}}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
